// File: rtl/serial_to_parallel_lane.sv
// Per-lane receive deserializer: comma hunt, preamble qualification,
// then one byte plus data-valid flag per eight bit-clock edges.
module serial_to_parallel_lane #(
    parameter logic [7:0]  COMMA    = 8'hBC,
    parameter int unsigned BC_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] lane_out,
    output logic       valid_out,
    output logic       active
);

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        ACTIVE
    } state_t;

    localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

    state_t     state, state_n;
    logic [7:0] sr;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [3:0] bc_cnt, bc_cnt_n;
    logic [7:0] lane_n;
    logic       valid_n;
    logic       active_n;

    logic [7:0] nxt;
    logic       boundary;
    logic       is_comma;

    assign nxt      = {sr[6:0], data_in};
    assign boundary = (bit_cnt == 3'd7);
    assign is_comma = (nxt == COMMA);

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            sr        <= 8'h00;
            bit_cnt   <= 3'd0;
            bc_cnt    <= 4'd0;
            lane_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= nxt;
            bit_cnt   <= bit_cnt_n;
            bc_cnt    <= bc_cnt_n;
            lane_out  <= lane_n;
            valid_out <= valid_n;
            active    <= active_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt + 3'd1;
        bc_cnt_n  = bc_cnt;
        lane_n    = lane_out;
        valid_n   = valid_out;
        active_n  = active;

        unique case (state)
            SEARCH: begin
                // Bit-granular hunt; the matching edge becomes the byte grid.
                if (is_comma) begin
                    bit_cnt_n = 3'd0;
                    bc_cnt_n  = 4'd1;
                    state_n   = ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        bc_cnt_n = bc_cnt + 4'd1;
                        if (bc_cnt + 4'd1 == BC_TARGET) begin
                            state_n  = ACTIVE;
                            active_n = 1'b1;
                        end
                    end else begin
                        bc_cnt_n = 4'd0;
                        state_n  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                // Commas here are idles, never a re-alignment trigger.
                if (boundary) begin
                    lane_n  = nxt;
                    valid_n = !is_comma;
                end
            end
            default: begin
                state_n = SEARCH;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_to_parallel_lane.sv
// Directed bench for serial_to_parallel_lane: alignment, broken preamble,
// idles in data, false cross-byte match and asynchronous reset.
module tb_serial_to_parallel_lane;

    logic       clk_8f;
    logic       reset;
    logic       data_in;
    logic [7:0] lane_out;
    logic       valid_out;
    logic       active;

    int checks;
    int failures;

    logic [7:0] cur_lane;
    logic       cur_valid;
    logic       cur_act;

    typedef struct {
        logic [7:0] data;
        logic [7:0] lane;
        logic       valid;
        logic       act;
    } vec_t;

    vec_t vecs [25];

    serial_to_parallel_lane dut (
        .clk_8f   (clk_8f),
        .reset    (reset),
        .data_in  (data_in),
        .lane_out (lane_out),
        .valid_out(valid_out),
        .active   (active)
    );

    initial clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    task automatic check(input string nm, input int bitn);
        checks++;
        if (lane_out !== cur_lane || valid_out !== cur_valid ||
            active !== cur_act) begin
            failures++;
            $display("FAIL %s bit%0d: got lane=%h valid=%b active=%b, want lane=%h valid=%b active=%b",
                     nm, bitn, lane_out, valid_out, active,
                     cur_lane, cur_valid, cur_act);
        end
    endtask

    task automatic send_bit(input logic b, input string nm);
        @(negedge clk_8f);
        data_in = b;
        @(posedge clk_8f);
        #1;
        check(nm, -1);
    endtask

    task automatic send_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d_%h", idx, v.data);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk_8f);
            data_in = v.data[i];
            @(posedge clk_8f);
            #1;
            if (i == 0) begin
                cur_lane  = v.lane;
                cur_valid = v.valid;
                cur_act   = v.act;
            end
            check(nm, i);
        end
    endtask

    task automatic pulse_reset_mid_byte(input string nm);
        logic [7:0] junk;
        junk = 8'hAA;
        for (int i = 7; i >= 5; i--) begin
            @(negedge clk_8f);
            data_in = junk[i];
            @(posedge clk_8f);
            #1;
            check({nm, "_pre"}, i);
        end
        #1;
        reset = 1'b1;
        #1;
        cur_lane  = 8'h00;
        cur_valid = 1'b0;
        cur_act   = 1'b0;
        check({nm, "_async"}, -1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_8f);
            data_in = ~data_in;
            @(posedge clk_8f);
            #1;
            check({nm, "_held"}, i);
        end
        @(negedge clk_8f);
        reset = 1'b0;
        data_in = 1'b0;
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic [7:0] l,
                                input logic v, input logic a);
        vec_t r;
        r.data  = d;
        r.lane  = l;
        r.valid = v;
        r.act   = a;
        return r;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = mk(8'hBC, 8'h00, 1'b0, 1'b0);
        vecs[1]  = mk(8'hBC, 8'h00, 1'b0, 1'b0);
        vecs[2]  = mk(8'hBC, 8'h00, 1'b0, 1'b0);
        vecs[3]  = mk(8'hBC, 8'h00, 1'b0, 1'b1);
        vecs[4]  = mk(8'h55, 8'h55, 1'b1, 1'b1);
        vecs[5]  = mk(8'h01, 8'h01, 1'b1, 1'b1);
        vecs[6]  = mk(8'hBC, 8'hBC, 1'b0, 1'b1);
        vecs[7]  = mk(8'h02, 8'h02, 1'b1, 1'b1);

        vecs[8]  = mk(8'hBC, 8'h00, 1'b0, 1'b0);
        vecs[9]  = mk(8'hBC, 8'h00, 1'b0, 1'b0);
        vecs[10] = mk(8'hBC, 8'h00, 1'b0, 1'b0);
        vecs[11] = mk(8'h12, 8'h00, 1'b0, 1'b0);
        vecs[12] = mk(8'hBC, 8'h00, 1'b0, 1'b0);
        vecs[13] = mk(8'hBC, 8'h00, 1'b0, 1'b0);
        vecs[14] = mk(8'hBC, 8'h00, 1'b0, 1'b0);
        vecs[15] = mk(8'hBC, 8'h00, 1'b0, 1'b1);
        vecs[16] = mk(8'hA7, 8'hA7, 1'b1, 1'b1);

        vecs[17] = mk(8'h0B, 8'h00, 1'b0, 1'b0);
        vecs[18] = mk(8'hC0, 8'h00, 1'b0, 1'b0);
        vecs[19] = mk(8'h00, 8'h00, 1'b0, 1'b0);
        vecs[20] = mk(8'hBC, 8'h00, 1'b0, 1'b0);
        vecs[21] = mk(8'hBC, 8'h00, 1'b0, 1'b0);
        vecs[22] = mk(8'hBC, 8'h00, 1'b0, 1'b0);
        vecs[23] = mk(8'hBC, 8'h00, 1'b0, 1'b1);
        vecs[24] = mk(8'h3C, 8'h3C, 1'b1, 1'b1);

        cur_lane  = 8'h00;
        cur_valid = 1'b0;
        cur_act   = 1'b0;
        reset     = 1'b1;
        data_in   = 1'b1;
        repeat (3) @(posedge clk_8f);
        #1;
        check("reset_state", -1);
        @(negedge clk_8f);
        reset   = 1'b0;
        data_in = 1'b0;

        // Three leading bits off the byte grid before the preamble.
        send_bit(1'b1, "prefix");
        send_bit(1'b0, "prefix");
        send_bit(1'b1, "prefix");
        for (int i = 0; i <= 7; i++) send_vec(vecs[i], i);

        pulse_reset_mid_byte("rst_active");
        for (int i = 8; i <= 16; i++) send_vec(vecs[i], i);

        pulse_reset_mid_byte("rst_before_false");
        for (int i = 17; i <= 24; i++) send_vec(vecs[i], i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, want completion");
        $fatal(1);
    end

endmodule

// File: doc/serial_to_parallel_lane.md
# serial_to_parallel_lane

Per-lane receive deserializer for the two-lane PHY receive path. It accepts the serial bit stream of one lane on the bit clock `clk_8f` and finds byte alignment by hunting for the comma character 0xBC. After a programmable run of consecutive commas it declares the lane active. It then delivers each received byte and a data-valid flag; these feed the `lane_N`/`valid_N` inputs of the byte unstriping stage at the byte rate (one byte per 8 `clk_8f` cycles, i.e. `clk_f`). The design instantiates one copy per lane.

## Interface
- `COMMA`, 8'hBC: idle/alignment character; never reported as valid data.
- `BC_COUNT`, 4: consecutive aligned commas required to enter ACTIVE; legal range 2..15.
- `clk_8f`  input  1  bit clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `data_in`  input  1  serial lane data, MSB of each byte first.
- `lane_out`  output  8  last byte captured in ACTIVE (registered).
- `valid_out`  output  1  1 when `lane_out` holds a non-comma byte (registered).
- `active`  output  1  1 while the lane is in ACTIVE (registered).

## Operation
- Shift register `sr[7:0]` loads `{sr[6:0], data_in}` every edge in every state. Call this value `nxt`; all comparisons use `nxt`.
- Bit counter `bit_cnt[2:0]` increments every edge and wraps 7→0.
- A byte boundary is an edge where `bit_cnt==7`. At that edge, `nxt` is a complete byte.
- Comma counter `bc_cnt[3:0]`.
- States:
  - SEARCH: reset state. The block checks `nxt==COMMA` on every edge, not only on boundaries.
    - On a match: `bit_cnt<=0`, `bc_cnt<=1`, go to ALIGN. That edge becomes the alignment point, so the next boundary is 8 edges later.
  - ALIGN: acts only at boundaries.
    - If `nxt==COMMA`: `bc_cnt<=bc_cnt+1`. If `bc_cnt+1==BC_COUNT`, go to ACTIVE.
    - If `nxt!=COMMA`: `bc_cnt<=0`, return to SEARCH. `bit_cnt` keeps counting, and bit-level search resumes on the next edge.
  - ACTIVE: acts only at boundaries.
    - `lane_out<=nxt`.
    - `valid_out<=(nxt!=COMMA)`.
    - Between boundaries, both outputs hold.
    - ACTIVE is left only by `reset`. Commas in ACTIVE are idles, not a re-alignment trigger.
- Outputs in SEARCH and ALIGN: `lane_out` holds 8'h00, `valid_out=0`, `active=0`.
- `active` is registered and rises on the same edge as the state change into ACTIVE.

## Timing
- Reset values (asynchronous; all clear while `reset`=1):
  - `sr=0`, `bit_cnt=0`, `bc_cnt=0`, state SEARCH.
  - `lane_out=8'h00`, `valid_out=0`, `active=0`.
- Alignment: the first comma is recognised on the edge that samples its LSB. Each further comma is confirmed 8 edges later.
  - With the default `BC_COUNT=4`, `active` rises on the edge sampling the LSB of the 4th comma, 24 edges after the first match.
- Data latency: a byte appears on `lane_out`/`valid_out` on the edge sampling its LSB. It is stable for the following 8 edges.
- Outputs update on at most one edge in every 8, which matches the `clk_f` rate expected downstream.
- Boundary conditions:
  - A false 0xBC match across two arbitrary bytes in SEARCH enters ALIGN. The next non-comma boundary returns to SEARCH, and no output changes.
  - A non-comma after `BC_COUNT-1` commas returns to SEARCH; `active` stays 0.
  - A comma at a boundary in ACTIVE gives `valid_out=0`, and `lane_out` shows 8'hBC.
  - `bc_cnt` cannot overflow: the maximum is `BC_COUNT`, and it stops on entering ACTIVE.
  - Reset asserted mid-byte in any state clears everything at once. After release, alignment starts over from SEARCH and the partially shifted byte is discarded.
  - `data_in` values during reset are ignored.

## Test plan
- Reset: assert `reset` mid-stream while ACTIVE → `lane_out=8'h00`, `valid_out=0`, `active=0` immediately, without waiting for an edge. After release, 4 commas are needed again.
- Alignment: send 3 random bits, then BC,BC,BC,BC,0x55 → `active` rises at the LSB of the 4th BC. `lane_out=8'h55` with `valid_out=1` at the LSB of 0x55, held for 8 edges.
- Broken preamble: send BC,BC,BC,0x12,BC,BC,BC,BC,0xA7 → `active` stays 0 through 0x12. It rises on the 4th BC of the second run, then `lane_out=8'hA7`, `valid_out=1`.
- Idle in data: in ACTIVE, send 0x01,BC,0x02 → `valid_out` goes 1,0,1 and `lane_out` goes 01,BC,02, each on its byte's LSB edge.
- False match: send 0x0B,0xC0, i.e. bits forming 0xBC across the byte boundary, then 0x00 → ALIGN entered and then SEARCH. `active=0` and `valid_out=0` throughout.
- Two-lane system: drive two instances with interleaved bytes 0x10..0x1F after preambles, feeding unstriping → unstriping `data_out` yields 0x10..0x1F in order at `clk_2f`.
